// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter in front of a synchronous FIFO.
// Several requesters compete for the single FIFO write port. The grant is
// combinational, so there is no latency from request to grant. A transfer
// happens at a clock edge when i_req[k] and o_gnt[k] are both high.
// Optional build macro: FIFO_WR_ARB_LOCK_EN adds the i_lock input and a
// lock owner. While a requester holds the lock, only it can be granted.
module fifo_wr_arb #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
`ifdef FIFO_WR_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]            i_lock,
`endif
   output logic [NUM_REQ-1:0]            o_gnt,
   input  logic                          i_fifo_full,
   output logic                          o_fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         o_fifo_data,
   output logic [2:0]                    o_last_gnt,
   output logic [15:0]                   o_xfer_cnt
);

   logic [2:0]         ptr;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] gnt;
   logic [2:0]         gnt_idx;
   logic               found;
   logic               xfer;

`ifdef FIFO_WR_ARB_LOCK_EN
   logic       lock_vld;
   logic [2:0] lock_own;
   logic       owner_req;
   logic       gnt_lock;

   // While a lock is held, mask every requester except the owner.
   always_comb begin
      eligible  = '0;
      owner_req = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         eligible[k] = i_req[k] && (!lock_vld || (lock_own == 3'(k)));
         if (lock_own == 3'(k))
            owner_req = i_req[k];
      end
   end
`else
   // Pure round-robin: every requester can be granted.
   always_comb begin
      eligible = i_req;
   end
`endif

   // Choose the eligible requester closest after ptr, wrapping around.
   // Reset and a full FIFO both block the grant, so no write is issued.
   always_comb begin
      int best_d;
      int d;
      int sel;
      best_d  = NUM_REQ;
      d       = 0;
      sel     = 0;
      found   = 1'b0;
      gnt     = '0;
      gnt_idx = '0;
      if (rst_n && !i_fifo_full) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            d = (k + 2*NUM_REQ - int'(ptr) - 1) % NUM_REQ;
            if (eligible[k] && (d < best_d)) begin
               best_d = d;
               sel    = k;
               found  = 1'b1;
            end
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (found && (sel == k))
            gnt[k] = 1'b1;
      end
      gnt_idx = 3'(sel);
   end

   // Drive the FIFO write port: data from the granted slice, otherwise zero.
   always_comb begin
      o_fifo_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt[k])
            o_fifo_data = o_fifo_data | i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
      o_gnt        = gnt;
      xfer         = |(i_req & gnt);
      o_fifo_wr_en = xfer;
   end

   // On each transfer, move the pointer to the winner and update the statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= 3'(NUM_REQ-1);
         o_last_gnt <= 3'd0;
         o_xfer_cnt <= 16'd0;
      end else if (xfer) begin
         ptr        <= gnt_idx;
         o_last_gnt <= gnt_idx;
         o_xfer_cnt <= o_xfer_cnt + 16'd1;
      end
   end

`ifdef FIFO_WR_ARB_LOCK_EN
   // i_lock of the current winner, selected without a variable index.
   always_comb begin
      gnt_lock = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt[k])
            gnt_lock = i_lock[k];
      end
   end

   // Take the lock on a locked transfer. Release it when the owner drops its
   // request, or when the owner makes a transfer with i_lock low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_vld <= 1'b0;
         lock_own <= 3'd0;
      end else if (lock_vld && !owner_req) begin
         lock_vld <= 1'b0;
      end else if (xfer) begin
         if (gnt_lock) begin
            lock_vld <= 1'b1;
            lock_own <= gnt_idx;
         end else begin
            lock_vld <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: scoreboard bench for fifo_wr_arb.
// The driver applies one set of inputs per cycle. It pushes the response the
// reference model predicts into a queue. A monitor on the falling edge pops
// each entry and compares it with the DUT outputs.
module tb_fifo_wr_arb;
   localparam int N = 4;
   localparam int W = 8;

   typedef struct packed {
      logic [N-1:0] gnt;
      logic         wr;
      logic [W-1:0] data;
      logic [2:0]   last;
      logic [15:0]  cnt;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     i_req;
   logic [N*W-1:0]   i_data;
   logic             i_fifo_full;
   logic [N-1:0]     o_gnt;
   logic             o_fifo_wr_en;
   logic [W-1:0]     o_fifo_data;
   logic [2:0]       o_last_gnt;
   logic [15:0]      o_xfer_cnt;
`ifdef FIFO_WR_ARB_LOCK_EN
   logic [N-1:0]     i_lock;
   initial i_lock = '0;
`endif

   int total;
   int bad;
   exp_t sb_q[$];

   // Reference model state
   int          m_ptr;
   int          m_last;
   logic [15:0] m_cnt;

   fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_req(i_req),
      .i_data(i_data),
`ifdef FIFO_WR_ARB_LOCK_EN
      .i_lock(i_lock),
`endif
      .o_gnt(o_gnt),
      .i_fifo_full(i_fifo_full),
      .o_fifo_wr_en(o_fifo_wr_en),
      .o_fifo_data(o_fifo_data),
      .o_last_gnt(o_last_gnt),
      .o_xfer_cnt(o_xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // One cycle of stimulus. Drive the inputs, predict the outputs, push the
   // prediction, then apply this cycle's transfer to the model.
   task automatic cyc(input logic [N-1:0] req, input logic [N*W-1:0] data,
                      input logic full, input logic rb);
      exp_t e;
      int   order[$];
      int   g;
      @(posedge clk);
      #1;
      rst_n       = rb;
      i_req       = req;
      i_data      = data;
      i_fifo_full = full;
      g = -1;
      if (!rb) begin
         m_ptr  = N-1;
         m_last = 0;
         m_cnt  = 16'd0;
      end else if (!full) begin
         order = {};
         for (int i = 1; i <= N; i++) order.push_back((m_ptr + i) % N);
         foreach (order[i]) if (g < 0 && req[order[i]]) g = order[i];
      end
      e.gnt  = (g >= 0) ? N'(1 << g) : '0;
      e.wr   = (g >= 0);
      e.data = (g >= 0) ? data[g*W +: W] : '0;
      e.last = 3'(m_last);
      e.cnt  = m_cnt;
      sb_q.push_back(e);
      if (g >= 0) begin
         m_ptr  = g;
         m_last = g;
         m_cnt  = m_cnt + 16'd1;
      end
   endtask

   function automatic logic [N*W-1:0] rand_data();
      logic [N*W-1:0] d;
      for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
      return d;
   endfunction

   // Monitor: compare every presented output against the next scoreboard entry.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("gnt",  32'(o_gnt),        32'(e.gnt));
         check("wr_en",32'(o_fifo_wr_en), 32'(e.wr));
         check("data", 32'(o_fifo_data),  32'(e.data));
         check("last", 32'(o_last_gnt),   32'(e.last));
         check("cnt",  32'(o_xfer_cnt),   32'(e.cnt));
      end else if (o_fifo_wr_en === 1'b1) begin
         check("unexpected_wr", 32'(o_fifo_wr_en), 32'd0);
      end
   end

   initial begin
      int drain;
      total = 0; bad = 0;
      rst_n = 1'b0; i_req = '0; i_data = '0; i_fifo_full = 1'b0;
      m_ptr = N-1; m_last = 0; m_cnt = 16'd0;

      // Reset, then all requesters ask: grants 0,1,2,3
      cyc('0, '0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
      repeat (4) cyc(4'b1111, rand_data(), 1'b0, 1'b1);
      cyc('0, '0, 1'b0, 1'b1);
      @(negedge clk);
      check("rr4_cnt",  32'(o_xfer_cnt), 32'd4);
      check("rr4_last", 32'(o_last_gnt), 32'd3);

      // Two requesters alternate
      repeat (3) cyc(4'b0101, 32'h00C2_00A0, 1'b0, 1'b1);

      // FIFO full in cycles 2-3, arbitration resumes from the unchanged ptr
      for (int c = 1; c <= 5; c++)
         cyc(4'b1111, rand_data(), (c == 2 || c == 3), 1'b1);

      // Random traffic
      repeat (300) cyc(N'($urandom), rand_data(), ($urandom_range(0, 3) == 0), 1'b1);

      // Reset pulse during continuous request from requester 1
      cyc(4'b0010, rand_data(), 1'b0, 1'b1);
      cyc(4'b0010, rand_data(), 1'b0, 1'b0);
      cyc(4'b0010, rand_data(), 1'b0, 1'b1);
      cyc(4'b0010, rand_data(), 1'b0, 1'b1);

      // Long run up to 16'hFFFE, then three more transfers wrap to 16'h0001
      while (m_cnt != 16'hFFFE) cyc(4'b1111, 32'h4433_2211, 1'b0, 1'b1);
      cyc('0, '0, 1'b0, 1'b1);
      @(negedge clk);
      check("cnt_fffe", 32'(o_xfer_cnt), 32'h0000_FFFE);
      repeat (3) cyc(4'b1111, rand_data(), 1'b0, 1'b1);
      cyc('0, '0, 1'b0, 1'b1);
      @(negedge clk);
      check("cnt_wrap", 32'(o_xfer_cnt), 32'h0000_0001);

      drain = 0;
      while (sb_q.size() > 0 && drain < 10) begin
         @(posedge clk);
         drain++;
      end
      if (sb_q.size() > 0) check("drain", 32'(sb_q.size()), 32'd0);
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
